// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants up to two writeback requesters per cycle and registers them onto the CDB.
// CDB_AGE_PRIO_EN selects oldest-first age priority; when it is undefined, selection is round-robin.
package uarch_pkg;
   localparam int unsigned TAG_WIDTH   = 5;
   localparam int unsigned ROB_ENTRIES = 1 << TAG_WIDTH;
   localparam int unsigned DATA_WIDTH  = 32;

   typedef struct packed {
      logic                  is_valid;
      logic [TAG_WIDTH-1:0]  dest_tag;
      logic [DATA_WIDTH-1:0] value;
   } writeback_packet_t;
endpackage

module cdb_arbiter
   import uarch_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ROB_DEPTH = ROB_ENTRIES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [TAG_WIDTH-1:0] rob_head,
   input  writeback_packet_t    fu_wb [NUM_REQ],
   output logic [NUM_REQ-1:0]   fu_ready,
   output writeback_packet_t    cdb_port0,
   output writeback_packet_t    cdb_port1
);
   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned AGE_W = $clog2(ROB_DEPTH);

   logic [AGE_W-1:0]   age [NUM_REQ];
   logic [NUM_REQ-1:0] req;
   logic [PTR_W-1:0]   sel0, sel1, rr_ptr, rr_next;
   logic               have0, have1;

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         age[i] = AGE_W'(fu_wb[i].dest_tag - rob_head);
         req[i] = fu_wb[i].is_valid & ~rst & ~flush;
      end
   end

`ifdef CDB_AGE_PRIO_EN
   logic unused_rr;
   assign unused_rr = ^rr_ptr;

   // Strict less-than keeps the lower index on equal ages.
   always_comb begin
      have0   = 1'b0;
      have1   = 1'b0;
      sel0    = '0;
      sel1    = '0;
      rr_next = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req[i] && (!have0 || age[i] < age[sel0])) begin
            sel0  = PTR_W'(i);
            have0 = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req[i] && have0 && PTR_W'(i) != sel0 && (!have1 || age[i] < age[sel1])) begin
            sel1  = PTR_W'(i);
            have1 = 1'b1;
         end
      end
   end
`else
   logic unused_age;
   logic [PTR_W-1:0] last;
   int unsigned idx;

   always_comb begin
      unused_age = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) unused_age = unused_age ^ (^age[i]);
   end

   always_comb begin
      have0 = 1'b0;
      have1 = 1'b0;
      sel0  = '0;
      sel1  = '0;
      idx   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[PTR_W'(idx)]) begin
            if (!have0) begin
               sel0  = PTR_W'(idx);
               have0 = 1'b1;
            end else if (!have1) begin
               sel1  = PTR_W'(idx);
               have1 = 1'b1;
            end
         end
      end
      last = have1 ? sel1 : sel0;
      if (!have0)                      rr_next = rr_ptr;
      else if (32'(last) + 1 == NUM_REQ) rr_next = '0;
      else                             rr_next = last + 1'b1;
   end
`endif

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++)
         fu_ready[i] = (have0 && sel0 == PTR_W'(i)) || (have1 && sel1 == PTR_W'(i));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_port0 <= '0;
         cdb_port1 <= '0;
         rr_ptr    <= '0;
      end else begin
         cdb_port0 <= have0 ? fu_wb[sel0] : '0;
         cdb_port1 <= have1 ? fu_wb[sel1] : '0;
         rr_ptr    <= rr_next;
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized plus directed bench for cdb_arbiter against a sort-based reference model.
// The model follows CDB_AGE_PRIO_EN the same way the design does.
module tb_cdb_arbiter;
   import uarch_pkg::*;
   localparam int N = 4;

   logic              clk = 1'b0;
   logic              rst, flush;
   logic [TAG_WIDTH-1:0] rob_head;
   writeback_packet_t fu_wb [N];
   logic [N-1:0]      fu_ready;
   writeback_packet_t cdb_port0, cdb_port1;

   int checks = 0;
   int failures = 0;
   int m_ptr = 0;
   writeback_packet_t exp_p0, exp_p1;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_REQ(N), .ROB_DEPTH(ROB_ENTRIES)) dut (
      .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
      .fu_wb(fu_wb), .fu_ready(fu_ready), .cdb_port0(cdb_port0), .cdb_port1(cdb_port1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Sort key: priority rank times N plus index, so the index is recoverable and ties favour lower index.
   function automatic int rank_key(input int i);
      int r;
`ifdef CDB_AGE_PRIO_EN
      r = (int'(fu_wb[i].dest_tag) + int'(ROB_ENTRIES) - int'(rob_head)) % int'(ROB_ENTRIES);
`else
      r = (i + N - m_ptr) % N;
`endif
      return r * N + i;
   endfunction

   function automatic writeback_packet_t rnd_pkt();
      writeback_packet_t p;
      p.is_valid = 1'b1;
      p.dest_tag = TAG_WIDTH'($urandom);
      p.value    = $urandom;
      return p;
   endfunction

   // Inputs are set just after a negedge; checks grants, then the registered ports, then retires grants.
   task automatic run_cycle(input string tag);
      int q[$];
      logic [N-1:0] exp_rdy;
      #1;
      if (!rst && !flush)
         for (int i = 0; i < N; i++) if (fu_wb[i].is_valid) q.push_back(rank_key(i));
      q.sort();
      exp_rdy = '0;
      exp_p0  = '0;
      exp_p1  = '0;
      if (q.size() > 0) begin exp_rdy[q[0] % N] = 1'b1; exp_p0 = fu_wb[q[0] % N]; end
      if (q.size() > 1) begin exp_rdy[q[1] % N] = 1'b1; exp_p1 = fu_wb[q[1] % N]; end
      check({tag, "/fu_ready"}, 64'(fu_ready), 64'(exp_rdy));
      if (rst)               m_ptr = 0;
      else if (q.size() > 1) m_ptr = (q[1] % N + 1) % N;
      else if (q.size() > 0) m_ptr = (q[0] % N + 1) % N;
      @(posedge clk);
      #1;
      check({tag, "/port0"}, 64'(cdb_port0), 64'(exp_p0));
      check({tag, "/port1"}, 64'(cdb_port1), 64'(exp_p1));
      @(negedge clk);
      for (int i = 0; i < N; i++) if (exp_rdy[i]) fu_wb[i] = '0;
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      rob_head = '0;
      for (int i = 0; i < N; i++) fu_wb[i] = '0;
      @(negedge clk);
      run_cycle("reset");
      run_cycle("reset");
      rst = 1'b0;

      for (int c = 0; c < 5; c++) run_cycle("idle");

`ifdef CDB_AGE_PRIO_EN
      rob_head = 5'd30;
      fu_wb[0] = rnd_pkt(); fu_wb[0].dest_tag = 5'd1;
      fu_wb[1] = rnd_pkt(); fu_wb[1].dest_tag = 5'd31;
      fu_wb[2] = rnd_pkt(); fu_wb[2].dest_tag = 5'd29;
      #1 check("age3/rdy", 64'(fu_ready), 64'(4'b0011));
      run_cycle("age3");
      check("age3/p0tag", 64'(cdb_port0.dest_tag), 64'd31);
      check("age3/p1tag", 64'(cdb_port1.dest_tag), 64'd1);
      check("age3/hold_rdy", 64'(fu_ready), 64'(4'b0100));
      run_cycle("age3_hold");
      check("age3/hold_tag", 64'(cdb_port0.dest_tag), 64'd29);
      check("age3/hold_p1v", 64'(cdb_port1.is_valid), 64'd0);
`endif

      fu_wb[3] = rnd_pkt(); fu_wb[3].dest_tag = 5'd5;
      #1 check("single/rdy", 64'(fu_ready), 64'(4'b1000));
      run_cycle("single");
      check("single/p0tag", 64'(cdb_port0.dest_tag), 64'd5);
      check("single/p1v", 64'(cdb_port1.is_valid), 64'd0);

      for (int i = 0; i < N; i++) fu_wb[i] = rnd_pkt();
      run_cycle("pre_flush");
      for (int i = 0; i < N; i++) if (!fu_wb[i].is_valid) fu_wb[i] = rnd_pkt();
      flush = 1'b1;
      #1 check("flush/rdy", 64'(fu_ready), 64'd0);
      check("flush/held_p0", 64'(cdb_port0), 64'(exp_p0));
      check("flush/held_p0v", 64'(cdb_port0.is_valid), 64'd1);
      run_cycle("flush");
      check("flush/p0v", 64'(cdb_port0.is_valid), 64'd0);
      check("flush/p1v", 64'(cdb_port1.is_valid), 64'd0);
      flush = 1'b0;
      for (int i = 0; i < N; i++) fu_wb[i] = '0;

      rob_head = '0;
      fu_wb[0] = rnd_pkt(); fu_wb[0].dest_tag = 5'd7;
      fu_wb[1] = rnd_pkt(); fu_wb[1].dest_tag = 5'd8;
      run_cycle("pre_rst");
      check("pre_rst/tags", 64'(cdb_port0.dest_tag) + 64'(cdb_port1.dest_tag), 64'd15);
      fu_wb[2] = rnd_pkt();
      rst = 1'b1;
      #1 check("mid_rst/rdy", 64'(fu_ready), 64'd0);
      run_cycle("mid_rst");
      rst = 1'b0;

`ifndef CDB_AGE_PRIO_EN
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < N; i++) if (!fu_wb[i].is_valid) fu_wb[i] = rnd_pkt();
         #1 check("rr/pair", 64'(fu_ready), (c == 1) ? 64'(4'b1100) : 64'(4'b0011));
         run_cycle("rr");
      end
`endif

      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!fu_wb[i].is_valid && $urandom_range(0, 1) == 1) fu_wb[i] = rnd_pkt();
         flush = ($urandom_range(0, 19) == 0);
         rst   = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 3) == 0) rob_head = TAG_WIDTH'($urandom);
         run_cycle("rand");
         if (flush)
            for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) fu_wb[i] = '0;
      end
      rst = 1'b0;
      flush = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
